// File: rtl/servo_xy_scheduler.sv
// rtl/servo_xy_scheduler.sv - frame-paced X/Y servo setpoint scheduler
// Optional slew limiting is compiled in with SERVO_XY_SLEW_EN.
module servo_xy_scheduler #(
  parameter int FRAME_CYCLES = 20000,
  parameter int PW_MIN       = 64,
  parameter int PW_MAX       = 192,
  parameter int STEP         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cmd_valid,
  input  logic       cmd_axis,
  input  logic [7:0] cmd_pos,
  output logic       cmd_ready,
  output logic [7:0] x_pw_o,
  output logic [7:0] y_pw_o,
  output logic       upd_o,
  output logic       busy_o
);

  localparam int             CW       = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [7:0]     PW_LO    = 8'(PW_MIN);
  localparam logic [7:0]     PW_HI    = 8'(PW_MAX);
  localparam logic [7:0]     PW_MID   = 8'((PW_MIN + PW_MAX) / 2);
  localparam logic [7:0]     STEP_U   = 8'((STEP > 255) ? 255 : STEP);
`ifdef SERVO_XY_SLEW_EN
  localparam bit             SLEW_ON  = 1'b1;
`else
  localparam bit             SLEW_ON  = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

  function automatic logic [7:0] clamp_pw(input logic [7:0] pos);
    logic [7:0] r;
    r = pos;
    if (pos < PW_LO) r = PW_LO;
    else if (pos > PW_HI) r = PW_HI;
    return r;
  endfunction

  // Target is always inside [PW_LO, PW_HI], so a bounded step toward it stays in range.
  function automatic logic [7:0] step_axis(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] diff;
    logic signed [9:0] diff_w;
    logic signed [9:0] step_s;
    logic [7:0]        r;
    diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    diff_w = {diff[8], diff};
    step_s = $signed({2'b00, STEP_U});
    r      = tgt;
    if (SLEW_ON) begin
      if (diff_w > step_s) r = cur + STEP_U;
      else if (diff_w < -step_s) r = cur - STEP_U;
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [7:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]    x_pw_q, x_pw_d, y_pw_q, y_pw_d;
  logic          upd_q, upd_d, busy_q, busy_d;
  logic          tick, accept;

  always_comb begin
    tick      = (cnt_q == CNT_LAST) && ena;
    cnt_d     = cnt_q;
    if (ena) cnt_d = tick ? '0 : cnt_q + CW'(1);

    cmd_ready = rst_n && ena && (state_q == IDLE);
    accept    = cmd_valid && cmd_ready;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    if (accept && !cmd_axis) tgt_x_d = clamp_pw(cmd_pos);
    if (accept &&  cmd_axis) tgt_y_d = clamp_pw(cmd_pos);

    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = STEP_X;
      STEP_X:  state_d = STEP_Y;
      STEP_Y:  state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cur_x_d = (state_q == STEP_X) ? step_axis(cur_x_q, tgt_x_q) : cur_x_q;
    cur_y_d = (state_q == STEP_Y) ? step_axis(cur_y_q, tgt_y_q) : cur_y_q;

    // Outputs latch on the edge into COMMIT; cur_y is updated on that same edge.
    x_pw_d = x_pw_q;
    y_pw_d = y_pw_q;
    if (state_q == STEP_Y) begin
      x_pw_d = cur_x_q;
      y_pw_d = cur_y_d;
    end
    upd_d  = (state_q == STEP_Y);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_x_q <= PW_MID;
      tgt_y_q <= PW_MID;
      cur_x_q <= PW_MID;
      cur_y_q <= PW_MID;
      x_pw_q  <= PW_MID;
      y_pw_q  <= PW_MID;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      x_pw_q  <= x_pw_d;
      y_pw_q  <= y_pw_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  assign x_pw_o = x_pw_q;
  assign y_pw_o = y_pw_q;
  assign upd_o  = upd_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_servo_xy_scheduler.sv
// tb/tb_servo_xy_scheduler.sv - directed self-checking bench for servo_xy_scheduler
// Expectations follow SERVO_XY_SLEW_EN when defined.
module tb_servo_xy_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, ena, cmd_valid, cmd_axis;
  logic [7:0] cmd_pos;
  logic       cmd_ready, upd_o, busy_o;
  logic [7:0] x_pw_o, y_pw_o;

  int checks = 0;
  int errors = 0;
  int mx, my, mtx, mty;

`ifdef SERVO_XY_SLEW_EN
  localparam int X1_EXP = 132;
`else
  localparam int X1_EXP = 192;
`endif

  servo_xy_scheduler #(.FRAME_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_axis(cmd_axis),
    .cmd_pos(cmd_pos), .cmd_ready(cmd_ready), .x_pw_o(x_pw_o), .y_pw_o(y_pw_o),
    .upd_o(upd_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mclamp(input int p);
    return (p < 64) ? 64 : ((p > 192) ? 192 : p);
  endfunction

  function automatic int mstep(input int c, input int t);
`ifdef SERVO_XY_SLEW_EN
    if (t - c > 4) return c + 4;
    if (c - t > 4) return c - 4;
`endif
    return t;
  endfunction

  task automatic frame(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!upd_o && n < 40);
    check({tag, "_upd"}, upd_o, 1);
    mx = mstep(mx, mtx);
    my = mstep(my, mty);
    check({tag, "_x"}, x_pw_o, mx);
    check({tag, "_y"}, y_pw_o, my);
  endtask

  task automatic send(input logic ax, input int pos);
    int n;
    n = 0;
    while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
    check("send_rdy", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_axis = ax; cmd_pos = 8'(pos);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (ax) mty = mclamp(pos); else mtx = mclamp(pos);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt_upd;
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_axis = 1'b0; cmd_pos = 8'd0;
    mx = 128; my = 128; mtx = 128; mty = 128;
    repeat (3) @(negedge clk);
    check("rst_x", x_pw_o, 128);
    check("rst_y", y_pw_o, 128);
    check("rst_upd", upd_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rdy", cmd_ready, 0);

    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("upd_c%0d", k), upd_o, (k == 18 || k == 34) ? 1 : 0);
      if (k >= 16 && k <= 18) check($sformatf("busy_c%0d", k), busy_o, 1);
    end
    check("idle_x", x_pw_o, 128);
    check("idle_y", y_pw_o, 128);

    send(1'b0, 200);
    frame("x200_f1");
    check("x200_first", x_pw_o, X1_EXP);
    repeat (3) frame("x200_f");

    send(1'b1, 10);
    repeat (4) frame("y10_f");

    send(1'b0, 100);
    send(1'b0, 150);
    frame("lww");

    repeat (13) @(negedge clk);
    check("hs_tick_rdy", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_axis = 1'b1; cmd_pos = 8'd180;
    @(negedge clk);
    mty = 180;
    check("hs_stepx_rdy", cmd_ready, 0);
    cmd_pos = 8'd70;
    @(negedge clk);
    check("hs_stepy_rdy", cmd_ready, 0);
    @(negedge clk);
    check("hs_commit_rdy", cmd_ready, 0);
    check("hs_commit_upd", upd_o, 1);
    mx = mstep(mx, mtx);
    my = mstep(my, mty);
    check("hs_same_frame_y", y_pw_o, my);
    @(negedge clk);
    check("hs_idle_rdy", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    mty = 70;
    frame("hs_next");

    repeat (13) @(negedge clk);
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ena_finish_upd", upd_o, 1);
    mx = mstep(mx, mtx);
    my = mstep(my, mty);
    check("ena_finish_y", y_pw_o, my);
    cnt_upd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (upd_o) cnt_upd++;
    end
    check("ena_off_rdy", cmd_ready, 0);
    check("ena_off_upds", cnt_upd, 0);
    ena = 1'b1;
    frame("ena_resume");

    repeat (13) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ar_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("ar_x", x_pw_o, 128);
    check("ar_y", y_pw_o, 128);
    check("ar_busy0", busy_o, 0);
    check("ar_upd", upd_o, 0);
    check("ar_rdy", cmd_ready, 0);
    @(negedge clk);
    check("ar_no_commit", upd_o, 0);
    rst_n = 1'b1;
    mx = 128; my = 128; mtx = 128; mty = 128;
    frame("ar_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
